// File: rtl/find_mod_pitch.sv
`default_nettype none
// ============================================================================
//  Module   : find_mod_pitch
//  Purpose  : Fixed-point QR module pitch and module size from three finder centres.
//  Revision : 1.0  initial release
// ============================================================================
module find_mod_pitch #(
    parameter int COORD_W     = 9,
    parameter int FRAC_BITS   = 4,
    parameter int VERSION_W   = 6,
    parameter int VERSION_MAX = 40
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [COORD_W-1:0]              centers_x [2:0],
    input  logic [COORD_W-1:0]              centers_y [2:0],
    input  logic [VERSION_W-1:0]            version_in,
    input  logic                            start_in,
    output logic                            busy_out,
    output logic [COORD_W+FRAC_BITS:0]      pitch_h_out,
    output logic [COORD_W+FRAC_BITS:0]      pitch_v_out,
    output logic [COORD_W+FRAC_BITS:0]      pitch_avg_out,
    output logic [COORD_W-1:0]              mod_size_out,
    output logic                            pitch_valid_out,
    output logic                            err_out
);

    localparam int C_Q_W   = COORD_W + 1 + FRAC_BITS;
    localparam int C_M_W   = COORD_W + 1;
    localparam int C_S_W   = 8;
    localparam int C_CNT_W = $clog2(C_Q_W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ABS  = 3'd1,
        ST_MAG  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [COORD_W-1:0]   r_x [2:0];
    logic [COORD_W-1:0]   r_y [2:0];
    logic [VERSION_W-1:0] r_ver;
    logic                 r_ver_bad;
    logic [COORD_W-1:0]   r_dx_h, r_dy_h, r_dx_v, r_dy_v;
    logic [C_M_W-1:0]     r_mag_h, r_mag_v;
    logic [C_S_W-1:0]     r_span;
    logic [C_Q_W-1:0]     r_dvd_h, r_dvd_v, r_quo_h, r_quo_v;
    logic [C_S_W-1:0]     r_rem_h, r_rem_v;
    logic [C_CNT_W-1:0]   r_cnt;

    function automatic logic [COORD_W-1:0] f_absdiff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Octagonal distance estimate: max + 3/8*min without a multiplier
    function automatic logic [C_M_W-1:0] f_mag(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
        logic [COORD_W-1:0] mx;
        logic [COORD_W-1:0] mn;
        mx = (a >= b) ? a : b;
        mn = (a >= b) ? b : a;
        return C_M_W'(mx) + C_M_W'(mn >> 2) + C_M_W'(mn >> 3);
    endfunction

    logic [C_M_W-1:0]   w_mag_h, w_mag_v;
    logic [C_S_W-1:0]   w_span;
    logic               w_ver_bad;
    logic [C_S_W:0]     w_trial_h, w_trial_v;
    logic               w_ge_h, w_ge_v;
    logic [C_Q_W-1:0]   w_ph, w_pv, w_hi, w_lo, w_gap, w_avg;
    logic [C_Q_W:0]     w_sum, w_round;
    logic [COORD_W-1:0] w_mod;
    logic               w_asym;

    always_comb begin
        w_mag_h   = f_mag(r_dx_h, r_dy_h);
        w_mag_v   = f_mag(r_dx_v, r_dy_v);
        w_span    = C_S_W'({r_ver, 2'b00}) + C_S_W'(10);
        w_ver_bad = (r_ver == '0) || (r_ver > VERSION_W'(VERSION_MAX));

        // Remainder stays below the span, so one bit of headroom is enough
        w_trial_h = {r_rem_h, r_dvd_h[C_Q_W-1]};
        w_trial_v = {r_rem_v, r_dvd_v[C_Q_W-1]};
        w_ge_h    = w_trial_h >= {1'b0, r_span};
        w_ge_v    = w_trial_v >= {1'b0, r_span};

        w_ph    = r_ver_bad ? '0 : r_quo_h;
        w_pv    = r_ver_bad ? '0 : r_quo_v;
        w_sum   = {1'b0, w_ph} + {1'b0, w_pv};
        w_avg   = C_Q_W'(w_sum >> 1);
        w_round = {1'b0, w_avg} + (C_Q_W+1)'(1 << (FRAC_BITS-1));
        w_mod   = COORD_W'(w_round >> FRAC_BITS);
        w_hi    = (w_ph >= w_pv) ? w_ph : w_pv;
        w_lo    = (w_ph >= w_pv) ? w_pv : w_ph;
        w_gap   = w_hi - w_lo;
        w_asym  = w_gap > (w_hi >> 2);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state         <= ST_IDLE;
            r_x             <= '{default: '0};
            r_y             <= '{default: '0};
            r_ver           <= '0;
            r_ver_bad       <= 1'b0;
            r_dx_h          <= '0;
            r_dy_h          <= '0;
            r_dx_v          <= '0;
            r_dy_v          <= '0;
            r_mag_h         <= '0;
            r_mag_v         <= '0;
            r_span          <= '0;
            r_dvd_h         <= '0;
            r_dvd_v         <= '0;
            r_quo_h         <= '0;
            r_quo_v         <= '0;
            r_rem_h         <= '0;
            r_rem_v         <= '0;
            r_cnt           <= '0;
            busy_out        <= 1'b0;
            pitch_h_out     <= '0;
            pitch_v_out     <= '0;
            pitch_avg_out   <= '0;
            mod_size_out    <= '0;
            pitch_valid_out <= 1'b0;
            err_out         <= 1'b0;
        end else begin
            pitch_valid_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    busy_out <= start_in;
                    if (start_in) begin
                        r_x     <= centers_x;
                        r_y     <= centers_y;
                        r_ver   <= version_in;
                        r_state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    r_dx_h  <= f_absdiff(r_x[1], r_x[0]);
                    r_dy_h  <= f_absdiff(r_y[1], r_y[0]);
                    r_dx_v  <= f_absdiff(r_x[2], r_x[0]);
                    r_dy_v  <= f_absdiff(r_y[2], r_y[0]);
                    r_state <= ST_MAG;
                end
                ST_MAG: begin
                    r_mag_h   <= w_mag_h;
                    r_mag_v   <= w_mag_v;
                    r_span    <= w_span;
                    r_ver_bad <= w_ver_bad;
                    r_dvd_h   <= {w_mag_h, {FRAC_BITS{1'b0}}};
                    r_dvd_v   <= {w_mag_v, {FRAC_BITS{1'b0}}};
                    r_rem_h   <= '0;
                    r_rem_v   <= '0;
                    r_quo_h   <= '0;
                    r_quo_v   <= '0;
                    r_cnt     <= '0;
                    r_state   <= ST_DIV;
                end
                ST_DIV: begin
                    r_rem_h <= C_S_W'(w_ge_h ? w_trial_h - {1'b0, r_span} : w_trial_h);
                    r_rem_v <= C_S_W'(w_ge_v ? w_trial_v - {1'b0, r_span} : w_trial_v);
                    r_quo_h <= {r_quo_h[C_Q_W-2:0], w_ge_h};
                    r_quo_v <= {r_quo_v[C_Q_W-2:0], w_ge_v};
                    r_dvd_h <= r_dvd_h << 1;
                    r_dvd_v <= r_dvd_v << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_W'(C_Q_W-1))
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    pitch_h_out     <= w_ph;
                    pitch_v_out     <= w_pv;
                    pitch_avg_out   <= w_avg;
                    mod_size_out    <= w_mod;
                    err_out         <= r_ver_bad || (r_mag_h == '0) || (r_mag_v == '0) || w_asym;
                    pitch_valid_out <= 1'b1;
                    r_state         <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_find_mod_pitch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_find_mod_pitch
//  Purpose  : Directed vector bench for find_mod_pitch with multi-cycle corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_find_mod_pitch;

    typedef struct {
        int x0, y0, x1, y1, x2, y2, ver;
        int eh, ev, ea, em, ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  cx [2:0];
    logic [8:0]  cy [2:0];
    logic [5:0]  ver = '0;
    logic        start = 1'b0;
    logic        busy, valid, err;
    logic [13:0] ph, pv, pa;
    logic [8:0]  ms;

    int n_cmp = 0;
    int n_err = 0;
    int cur_vec = -1;
    vec_t vecs [10];

    always #5 clk = ~clk;

    find_mod_pitch dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .centers_x       (cx),
        .centers_y       (cy),
        .version_in      (ver),
        .start_in        (start),
        .busy_out        (busy),
        .pitch_h_out     (ph),
        .pitch_v_out     (pv),
        .pitch_avg_out   (pa),
        .mod_size_out    (ms),
        .pitch_valid_out (valid),
        .err_out         (err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0d expected %0d", cur_vec, nm, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        cx[0] = 9'(v.x0); cy[0] = 9'(v.y0);
        cx[1] = 9'(v.x1); cy[1] = 9'(v.y1);
        cx[2] = 9'(v.x2); cy[2] = 9'(v.y2);
        ver   = 6'(v.ver);
    endtask

    task automatic check_result(input vec_t v);
        chk("pitch_h", int'(ph), v.eh);
        chk("pitch_v", int'(pv), v.ev);
        chk("pitch_avg", int'(pa), v.ea);
        chk("mod_size", int'(ms), v.em);
        chk("err", int'(err), v.ee);
    endtask

    task automatic run_vec(input int idx);
        int lat;
        cur_vec = idx;
        lat = -1;
        @(negedge clk);
        set_inputs(vecs[idx]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 17);
        if (lat > 0) begin
            check_result(vecs[idx]);
            chk("busy_during_valid", int'(busy), 1);
            @(posedge clk);
            #1;
            chk("valid_one_cycle", int'(valid), 0);
            chk("busy_dropped", int'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcount;
        int first;
        int h_cap, v_cap, a_cap, m_cap, e_cap;

        vecs[0] = '{100, 100, 240, 100, 100, 240, 1, 160, 160, 160, 10, 0};
        vecs[1] = '{100, 100, 180, 160,  40, 180, 1, 116, 116, 116,  7, 0};
        vecs[2] = '{ 50,  50, 230,  50,  50, 230, 2, 160, 160, 160, 10, 0};
        vecs[3] = '{100, 100, 240, 100, 100, 170, 1, 160,  80, 120,  8, 1};
        vecs[4] = '{  0,   0, 511,   0,   0, 511, 40,  48,  48,  48,  3, 0};
        vecs[5] = '{100, 100, 240, 100, 100, 240, 41,   0,   0,   0,  0, 1};
        vecs[6] = '{200, 200, 200, 200, 200, 200, 1,   0,   0,   0,  0, 1};
        vecs[7] = '{100, 100, 240, 100, 100, 205, 1, 160, 120, 140,  9, 0};
        vecs[8] = '{100, 100, 240, 100, 100, 204, 1, 160, 118, 139,  9, 1};
        vecs[9] = '{100, 100, 240, 100, 100, 240, 0,   0,   0,   0,  0, 1};

        set_inputs(vecs[0]);
        #23;
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_pitch_h", int'(ph), 0);
        chk("reset_mod_size", int'(ms), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_vec(i);

        // Start pulses while busy and in the DONE cycle, inputs scrambled after accept
        cur_vec = 0;
        @(negedge clk);
        set_inputs(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        set_inputs(vecs[3]);
        vcount = 0; first = -1;
        h_cap = -1; v_cap = -1; a_cap = -1; m_cap = -1; e_cap = -1;
        for (int k = 1; k <= 30; k++) begin
            start = (k == 3 || k == 16 || k == 17);
            @(posedge clk);
            #1;
            if (valid) begin
                vcount++;
                if (first < 0) begin
                    first = k;
                    h_cap = int'(ph); v_cap = int'(pv); a_cap = int'(pa);
                    m_cap = int'(ms); e_cap = int'(err);
                end
            end
        end
        start = 1'b0;
        chk("ignored_start_valid_count", vcount, 1);
        chk("ignored_start_latency", first, 17);
        chk("ignored_start_pitch_h", h_cap, 160);
        chk("ignored_start_pitch_v", v_cap, 160);
        chk("ignored_start_avg", a_cap, 160);
        chk("ignored_start_mod", m_cap, 10);
        chk("ignored_start_err", e_cap, 0);
        chk("ignored_start_idle", int'(busy), 0);

        run_vec(9);

        // Asynchronous reset mid-operation
        cur_vec = 0;
        @(negedge clk);
        set_inputs(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_pitch_h", int'(ph), 0);
        chk("async_rst_pitch_v", int'(pv), 0);
        chk("async_rst_avg", int'(pa), 0);
        chk("async_rst_mod", int'(ms), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        chk("no_valid_after_reset", vcount, 0);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
